// File: rtl/serial_alu_sequencer_pkg.sv
// Shared types for serial_alu_sequencer: ALU control width and FSM states.
// Optional feature macro used by the block: SERIAL_ALU_CARRY_IN_EN.
package serial_alu_sequencer_pkg;

  localparam int CONTROL_WIDTH = 5;
  localparam int MUX_WIDTH     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Bus between sequencer and its user/ALU: start, operands, result, bit-serial ALU link.
// slave = sequencer side; SERIAL_ALU_CARRY_IN_EN adds carry_in_i/borrow_in_i.
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 8
);
  import serial_alu_sequencer_pkg::*;

  logic                     start_i;
  logic [WIDTH-1:0]         a_i;
  logic [WIDTH-1:0]         b_i;
  logic [CONTROL_WIDTH-1:0] f_i;
  logic                     busy_o;
  logic                     done_o;
  logic [WIDTH-1:0]         result_o;
  logic                     carry_o;
  logic                     borrow_o;
  logic                     alu_a_o;
  logic                     alu_b_o;
  logic                     alu_carry_o;
  logic                     alu_borrow_o;
  logic [CONTROL_WIDTH-1:0] alu_f_o;
  logic                     alu_result_i;
  logic                     alu_carry_i;
  logic                     alu_borrow_i;
`ifdef SERIAL_ALU_CARRY_IN_EN
  logic                     carry_in_i;
  logic                     borrow_in_i;

  modport slave (
    input  start_i, a_i, b_i, f_i,
    input  alu_result_i, alu_carry_i, alu_borrow_i,
    input  carry_in_i, borrow_in_i,
    output busy_o, done_o, result_o, carry_o, borrow_o,
    output alu_a_o, alu_b_o, alu_carry_o, alu_borrow_o, alu_f_o
  );

  modport master (
    output start_i, a_i, b_i, f_i,
    output alu_result_i, alu_carry_i, alu_borrow_i,
    output carry_in_i, borrow_in_i,
    input  busy_o, done_o, result_o, carry_o, borrow_o,
    input  alu_a_o, alu_b_o, alu_carry_o, alu_borrow_o, alu_f_o
  );
`else
  modport slave (
    input  start_i, a_i, b_i, f_i,
    input  alu_result_i, alu_carry_i, alu_borrow_i,
    output busy_o, done_o, result_o, carry_o, borrow_o,
    output alu_a_o, alu_b_o, alu_carry_o, alu_borrow_o, alu_f_o
  );

  modport master (
    output start_i, a_i, b_i, f_i,
    output alu_result_i, alu_carry_i, alu_borrow_i,
    input  busy_o, done_o, result_o, carry_o, borrow_o,
    input  alu_a_o, alu_b_o, alu_carry_o, alu_borrow_o, alu_f_o
  );
`endif

endinterface

// File: rtl/serial_alu_sequencer_shift_register_lsb.sv
// shift_register_lsb: WIDTH-bit right shift register with parallel load.
// Ports: clk_i, rst_i, load_i/load_val_i, shift_i/ser_i (into MSB), q_o.
module shift_register_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {ser_i, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer feeding a 1-bit ALU LSB first; assembles WIDTH-bit result.
// Ports: clk_i, rst_i (async high), bus (slave); macro SERIAL_ALU_CARRY_IN_EN.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_alu_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     carry_q, carry_d;
  logic                     borrow_q, borrow_d;
  logic [CONTROL_WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0]         a_q, b_q, res_q;
  logic                     accept, shift_en, last;
  logic                     cin, bin;

`ifdef SERIAL_ALU_CARRY_IN_EN
  assign cin = bus.carry_in_i;
  assign bin = bus.borrow_in_i;
`else
  assign cin = 1'b0;
  assign bin = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && bus.start_i;
  assign shift_en = (state_q == SHIFT);
  assign last     = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    f_d      = f_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = SHIFT;
          count_d  = '0;
          carry_d  = cin;
          borrow_d = bin;
          f_d      = bus.f_i;
        end
      end
      SHIFT: begin
        carry_d  = bus.alu_carry_i;
        borrow_d = bus.alu_borrow_i;
        // hold the counter on the last bit so it never wraps
        if (last) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      f_q      <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      f_q      <= f_d;
    end
  end

  shift_register_lsb #(.WIDTH(WIDTH)) u_sr_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (bus.a_i),
    .shift_i    (shift_en),
    .ser_i      (1'b0),
    .q_o        (a_q)
  );

  shift_register_lsb #(.WIDTH(WIDTH)) u_sr_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (bus.b_i),
    .shift_i    (shift_en),
    .ser_i      (1'b0),
    .q_o        (b_q)
  );

  shift_register_lsb #(.WIDTH(WIDTH)) u_sr_res (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i ({WIDTH{1'b0}}),
    .shift_i    (shift_en),
    .ser_i      (bus.alu_result_i),
    .q_o        (res_q)
  );

  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.result_o     = res_q;
  assign bus.carry_o      = carry_q;
  assign bus.borrow_o     = borrow_q;
  assign bus.alu_a_o      = a_q[0];
  assign bus.alu_b_o      = b_q[0];
  assign bus.alu_carry_o  = carry_q;
  assign bus.alu_borrow_o = borrow_q;
  assign bus.alu_f_o      = f_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer with a behavioural 1-bit ALU and word-level model.
// Control word: f[2:0] op (0 AND,1 OR,2 XOR,3 ADD,4 SUB), f[3] B enable, f[4] invert.
module tb_serial_alu_sequencer;
  import serial_alu_sequencer_pkg::*;

  localparam int W = 8;
  localparam logic [4:0] F_ADD = 5'b01011;
  localparam logic [4:0] F_SUB = 5'b01100;
  localparam logic [4:0] F_AND_NOB = 5'b00000;
  localparam logic [4:0] F_OR_INV = 5'b11001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // behavioural single-bit ALU slice
  logic ab, ar;
  always_comb begin
    ab = bus.alu_f_o[3] & bus.alu_b_o;
    ar = 1'b0;
    case (bus.alu_f_o[2:0])
      3'd0: ar = bus.alu_a_o & ab;
      3'd1: ar = bus.alu_a_o | ab;
      3'd2: ar = bus.alu_a_o ^ ab;
      3'd3: ar = bus.alu_a_o ^ ab ^ bus.alu_carry_o;
      3'd4: ar = bus.alu_a_o ^ ab ^ bus.alu_borrow_o;
      default: ar = 1'b0;
    endcase
    bus.alu_result_i = ar ^ bus.alu_f_o[4];
    bus.alu_carry_i = (bus.alu_a_o & ab) | (bus.alu_a_o & bus.alu_carry_o)
                    | (ab & bus.alu_carry_o);
    bus.alu_borrow_i = (~bus.alu_a_o & ab)
                     | (~(bus.alu_a_o ^ ab) & bus.alu_borrow_o);
  end

  typedef struct {
    logic [W-1:0] res;
    logic c;
    logic bw;
    int e0;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int dones = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] f, input logic cin,
                                 input logic bin);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0] s, d;
    bb = f[3] ? b : '0;
    s = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
    d = {1'b0, a} - {1'b0, bb} - (W+1)'(bin);
    case (f[2:0])
      3'd0: e.res = a & bb;
      3'd1: e.res = a | bb;
      3'd2: e.res = a ^ bb;
      3'd3: e.res = s[W-1:0];
      3'd4: e.res = d[W-1:0];
      default: e.res = '0;
    endcase
    if (f[4]) e.res = ~e.res;
    e.c = s[W];
    e.bw = d[W];
    e.e0 = 0;
    return e;
  endfunction

  // monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      dones++;
      chk("done_pulse_width", 32'(prev_done), 0);
      chk("done_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("result", 32'(bus.result_o), 32'(me.res));
        chk("carry", 32'(bus.carry_o), 32'(me.c));
        chk("borrow", 32'(bus.borrow_o), 32'(me.bw));
        chk("latency", 32'(cyc - me.e0), W);
      end
    end
    prev_done = bus.done_o;
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] f, inout logic cin, inout logic bin);
    bus.a_i = a;
    bus.b_i = b;
    bus.f_i = f;
`ifdef SERIAL_ALU_CARRY_IN_EN
    bus.carry_in_i = cin;
    bus.borrow_in_i = bin;
`else
    cin = 1'b0;
    bin = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] f, input logic cin, input logic bin);
    exp_t e;
    logic c2, b2;
    c2 = cin;
    b2 = bin;
    wait_idle();
    drive(a, b, f, c2, b2);
    e = model(a, b, f, c2, b2);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    e.e0 = cyc;
    q.push_back(e);
    bus.start_i = 1'b0;
    chk("accepted_busy", 32'(bus.busy_o), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 0);
    wait_idle();
  endtask

  task automatic rnd_ops(output logic [W-1:0] a, output logic [W-1:0] b,
                         output logic [4:0] f);
    a = W'($urandom);
    b = W'($urandom);
    f = {1'($urandom), 1'($urandom), 3'($urandom_range(0, 4))};
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [4:0] rf;
    logic rc, rbw, pb;
    int d0, n, last;
    exp_t e;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.f_i = '0;
`ifdef SERIAL_ALU_CARRY_IN_EN
    bus.carry_in_i = 1'b0;
    bus.borrow_in_i = 1'b0;
`endif
    #1 rst = 1'b1;
    #11;
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_result", 32'(bus.result_o), 0);
    chk("rst_carry", 32'(bus.carry_o), 0);
    chk("rst_borrow", 32'(bus.borrow_o), 0);
    chk("rst_alu_f", 32'(bus.alu_f_o), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(8'h5A, 8'h3C, F_ADD, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, F_ADD, 1'b0, 1'b0);
    issue(8'h10, 8'h01, F_SUB, 1'b0, 1'b0);
    issue(8'h00, 8'h01, F_SUB, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, F_AND_NOB, 1'b0, 1'b0);
    issue(8'h0F, 8'h00, F_OR_INV, 1'b0, 1'b0);
    drain();
    chk("alu_f_held_idle", 32'(bus.alu_f_o), 32'(F_OR_INV));

    for (int i = 0; i < 20; i++) begin
      rnd_ops(ra, rb, rf);
      issue(ra, rb, rf, 1'($urandom), 1'($urandom));
    end
    drain();

    // start pulse while busy must be ignored
    d0 = dones;
    issue(8'h33, 8'h44, F_ADD, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.a_i = 8'hAA;
    bus.b_i = 8'hEE;
    bus.f_i = F_SUB;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("busy_start_dones", 32'(dones - d0), 1);

    // asynchronous reset mid-operation
    issue(8'h77, 8'h11, F_ADD, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy_o), 0);
    chk("mid_rst_done", 32'(bus.done_o), 0);
    chk("mid_rst_result", 32'(bus.result_o), 0);
    chk("mid_rst_carry", 32'(bus.carry_o), 0);
    chk("mid_rst_borrow", 32'(bus.borrow_o), 0);
    chk("mid_rst_alu_f", 32'(bus.alu_f_o), 0);
    q.delete();
    d0 = dones;
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("mid_rst_no_done", 32'(dones - d0), 0);
    issue(8'h5A, 8'h3C, F_ADD, 1'b0, 1'b0);
    drain();

    // start held high: back-to-back every W+2 cycles
    rnd_ops(ra, rb, rf);
    rc = 1'($urandom);
    rbw = 1'($urandom);
    drive(ra, rb, rf, rc, rbw);
    bus.start_i = 1'b1;
    pb = bus.busy_o;
    n = 0;
    last = 0;
    for (int c = 0; c < 6 * (W + 2) + 4 && n < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy_o && !pb) begin
        e = model(ra, rb, rf, rc, rbw);
        e.e0 = cyc;
        q.push_back(e);
        if (n > 0) chk("b2b_period", 32'(cyc - last), W + 2);
        last = cyc;
        n++;
        rnd_ops(ra, rb, rf);
        rc = 1'($urandom);
        rbw = 1'($urandom);
        drive(ra, rb, rf, rc, rbw);
      end
      pb = bus.busy_o;
    end
    bus.start_i = 1'b0;
    chk("b2b_count", 32'(n), 5);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Bit-serial controller that sits directly upstream of `one_bit_alu`. It accepts a WIDTH-bit operand pair and a control word, feeds the single-bit ALU one bit pair per cycle (LSB first), and registers the ALU's carry/borrow between cycles. It assembles the serial result into a WIDTH-bit word and signals completion with a one-cycle `done_o` pulse. This lets the TinyTapeout design reuse one 1-bit ALU slice for multi-bit arithmetic and logic.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.
- `clk_i` input 1 — single clock, rising edge.
- `rst_i` input 1 — asynchronous, active-high reset.
- `start_i` input 1 — request an operation; sampled only in IDLE.
- `a_i` input WIDTH — operand A, latched on accepted start.
- `b_i` input WIDTH — operand B, latched on accepted start.
- `f_i` input `CONTROL_WIDTH` — ALU control word, latched on accepted start, forwarded unchanged.
- `busy_o` output 1 — high in SHIFT and DONE.
- `done_o` output 1 — one-cycle pulse in DONE.
- `result_o` output WIDTH — assembled result; valid from DONE until next accepted start.
- `carry_o` output 1 — final carry out; valid with `result_o`.
- `borrow_o` output 1 — final borrow out; valid with `result_o`.
- `alu_a_o` output 1, `alu_b_o` output 1 — current bit pair to ALU.
- `alu_carry_o` output 1, `alu_borrow_o` output 1 — registered carry/borrow into ALU.
- `alu_f_o` output `CONTROL_WIDTH` — latched control word.
- `alu_result_i` input 1, `alu_carry_i` input 1, `alu_borrow_i` input 1 — combinational ALU response in the same cycle.

## Operation
The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - When `start_i=1`: latch `a_i`, `b_i` and `f_i`; clear the bit counter; set the carry and borrow flops to 0; go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - Drive `alu_a_o`/`alu_b_o` from the LSB of the A/B shift registers.
  - On each edge:
    - shift A and B right by one;
    - shift `alu_result_i` into the MSB of the result register (right shift);
    - load carry ← `alu_carry_i` and borrow ← `alu_borrow_i`;
    - increment the counter.
  - At `count == WIDTH-1`, go to DONE.
- **DONE**
  - Assert `done_o`; `result_o`, `carry_o` and `borrow_o` hold their final values.
  - Go to IDLE unconditionally.
- `start_i` is ignored in SHIFT and DONE; there is no queuing.
- Accepted-start condition: `!busy_o && start_i`.
- `alu_f_o` holds its latched value through IDLE, so the ALU input stays stable.
- `result_o` is the result shift register. It changes during SHIFT; consumers sample it on `done_o` or in IDLE.
- Bit counter width is `$clog2(WIDTH)`. It never wraps within an operation and is cleared on every accepted start.
- `carry_o`/`borrow_o` are the carry/borrow flops after bit WIDTH-1.

## Timing
- Reset value of every register and output is 0. The FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately: no `done_o`, result cleared, FSM in IDLE.
- Start accepted at edge 0:
  - SHIFT for edges 1..WIDTH;
  - `done_o` high in cycle WIDTH+1;
  - next start accepted at the earliest at edge WIDTH+2.
- `start_i` held high continuously gives back-to-back operations every WIDTH+2 cycles.
- The ALU path is purely combinational within one cycle. The carry chain has a 1-cycle register between bit slices.

## Configuration
- Macro: `SERIAL_ALU_CARRY_IN_EN`.
- **Defined:** adds `carry_in_i` and `borrow_in_i` (input, 1 bit each), sampled on accepted start. They initialise the carry and borrow flops, which enables multi-word chaining.
- **Undefined:** the ports are absent and both flops initialise to 0.

## Structure
- Shared package / header holds:
  - `CONTROL_WIDTH` and `MUX_WIDTH` (existing);
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- Natural sub-module: `shift_register_lsb`, a parameterised WIDTH-bit right shift with parallel load. It is instantiated three times: for A, B and result.
- `one_bit_alu` is instantiated beside this block in the parent, not inside it.

## Test plan
All scenarios use `WIDTH=8` with the bench connected to a real `one_bit_alu`.
- **Add:** adder select, F3=1, F4=0, A=8'h5A, B=8'h3C → `result_o`=8'h96, `carry_o`=0, `done_o` in cycle 9 after the start edge.
- **Add with overflow:** A=8'hFF, B=8'h01 → `result_o`=8'h00, `carry_o`=1.
- **Subtract:**
  - A=8'h10, B=8'h01 → 8'h0F, `borrow_o`=0;
  - A=8'h00, B=8'h01 → 8'hFF, `borrow_o`=1.
- **Logic with B disabled:** AND select, F3=0, A=8'hFF, B=8'hFF → 8'h00. OR select with F4=1, A=8'h0F, B=8'h00, F3=1 → 8'hF0.
- **Start while busy:** pulse `start_i` with new operands at SHIFT cycle 3 → ignored; the first result completes unchanged and exactly one `done_o` occurs.
- **Reset mid-operation:** assert `rst_i` asynchronously at SHIFT cycle 4 → all outputs 0 immediately, no `done_o`. A new start after release completes normally.
